// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter feeding one byte at a time
// from four requesters into a single UART transmitter.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     per-requester send request (level)
//   req_data     requester i byte on [8i+7:8i]
//   grant[3:0]   one-hot pulse: requester byte captured
//   tx_data      byte presented to the transmitter
//   tx_en_sig    one-cycle start pulse to the transmitter
//   tx_done_sig  one-cycle pulse from the transmitter
//   busy         high whenever not idle
//   cur_id       owner of current/last transfer
//   err          one-cycle pulse on transmit timeout
module uart_tx_arb #(
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  grant,
  output logic [7:0]  tx_data,
  output logic        tx_en_sig,
  input  logic        tx_done_sig,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic        err
);

  localparam int MAXC =
    (GAP_CYC > TIMEOUT_CYC) ? GAP_CYC : TIMEOUT_CYC;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST =
    (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
  } state_t;

  // Where a finished or aborted transfer goes next.
  localparam state_t POST =
    (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    last_q;
  logic [3:0]    grant_q;
  logic          tx_en_q;
  logic          err_q;
  logic [7:0]    tx_data_q;
  logic [1:0]    cur_id_q;

  logic [1:0] win;
  logic [1:0] rr_idx;
  logic       hit;

  // Scan starts one past the last winner and wraps.
  always_comb begin
    win    = last_q;
    rr_idx = last_q;
    hit    = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_q + 2'(k);
      if (!hit && req[rr_idx]) begin
        hit = 1'b1;
        win = rr_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= 2'd3;
      grant_q   <= '0;
      tx_en_q   <= 1'b0;
      err_q     <= 1'b0;
      tx_data_q <= 8'h00;
      cur_id_q  <= 2'd0;
    end else begin
      grant_q <= '0;
      tx_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            grant_q   <= 4'b0001 << win;
            tx_en_q   <= 1'b1;
            tx_data_q <= req_data[{win, 3'b000} +: 8];
            cur_id_q  <= win;
            last_q    <= win;
            cnt_q     <= '0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // done wins over a same-cycle timeout
          if (tx_done_sig) begin
            cnt_q   <= '0;
            state_q <= POST;
          end else if (cnt_q == TO_LAST) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= POST;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign tx_en_sig = tx_en_q;
  assign err       = err_q;
  assign tx_data   = tx_data_q;
  assign cur_id    = cur_id_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: random + directed stimulus on two arbiter
// instances (with and without guard gap) against a reference.
module tb_uart_tx_arb;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        done0, done1;

  logic [3:0]  g0, g1;
  logic [7:0]  txd0, txd1;
  logic        en0, en1;
  logic        bz0, bz1;
  logic [1:0]  id0, id1;
  logic        er0, er1;

  always #5 clk = ~clk;

  uart_tx_arb #(.GAP_CYC(16), .TIMEOUT_CYC(TO)) u0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(g0), .tx_data(txd0), .tx_en_sig(en0),
    .tx_done_sig(done0), .busy(bz0), .cur_id(id0),
    .err(er0)
  );

  uart_tx_arb #(.GAP_CYC(0), .TIMEOUT_CYC(TO)) u1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(g1), .tx_data(txd1), .tx_en_sig(en1),
    .tx_done_sig(done1), .busy(bz1), .cur_id(id1),
    .err(er1)
  );

  // Reference: mode 0 idle, 1 sending, 2 guard gap.
  typedef struct {
    int         mode;
    int         age;
    int         left;
    int         last;
    logic [3:0] gnt;
    logic       en;
    logic       e;
    logic [7:0] data;
    int         id;
  } mdl_t;

  mdl_t m0, m1;

  int n_vec = 0;
  int n_bad = 0;

  bit         collect = 0;
  logic [3:0] gq[$];
  int         errs0 = 0;

  function automatic mdl_t step(
    input mdl_t m, input int gap,
    input logic r, input logic [3:0] rq,
    input logic [31:0] rd, input logic dn
  );
    mdl_t n = m;
    int   w = -1;
    bit   fin = 0;
    n.gnt = '0;
    n.en  = 1'b0;
    n.e   = 1'b0;
    if (r) begin
      n.mode = 0; n.age = 0; n.left = 0; n.last = 3;
      n.data = 8'h00; n.id = 0;
      return n;
    end
    if (m.mode == 0) begin
      if (rq != 0) begin
        for (int k = 1; k <= 4; k++)
          if (w < 0 && rq[(m.last + k) % 4])
            w = (m.last + k) % 4;
        n.gnt  = 4'(1 << w);
        n.en   = 1'b1;
        n.data = rd[8*w +: 8];
        n.id   = w;
        n.last = w;
        n.mode = 1;
        n.age  = 0;
      end
    end else if (m.mode == 1) begin
      if (dn) fin = 1;
      else if (m.age == TO - 1) begin
        n.e = 1'b1;
        fin = 1;
      end else n.age = m.age + 1;
      if (fin) begin
        n.mode = (gap == 0) ? 0 : 2;
        n.left = gap;
      end
    end else begin
      n.left = m.left - 1;
      if (n.left == 0) n.mode = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h",
               tag, $time, obs, exp);
    end
  endtask

  // dp<0: random done; else done when model age == dp
  task automatic cyc(input logic r, input logic [3:0] rq,
                     input logic [31:0] rd, input int dp);
    rst      = r;
    req      = rq;
    req_data = rd;
    if (dp < 0) begin
      done0 = ($urandom_range(0, 11) == 0);
      done1 = ($urandom_range(0, 11) == 0);
    end else begin
      done0 = (m0.mode == 1 && m0.age == dp);
      done1 = (m1.mode == 1 && m1.age == dp);
    end
    @(posedge clk);
    m0 = step(m0, 16, r, rq, rd, done0);
    m1 = step(m1, 0, r, rq, rd, done1);
    #1;
    chk("g0",   32'(g0),   32'(m0.gnt));
    chk("en0",  32'(en0),  32'(m0.en));
    chk("txd0", 32'(txd0), 32'(m0.data));
    chk("id0",  32'(id0),  32'(m0.id));
    chk("bz0",  32'(bz0),  32'(m0.mode != 0));
    chk("er0",  32'(er0),  32'(m0.e));
    chk("g1",   32'(g1),   32'(m1.gnt));
    chk("en1",  32'(en1),  32'(m1.en));
    chk("txd1", 32'(txd1), 32'(m1.data));
    chk("id1",  32'(id1),  32'(m1.id));
    chk("bz1",  32'(bz1),  32'(m1.mode != 0));
    chk("er1",  32'(er1),  32'(m1.e));
    if (collect && g0 != 0) gq.push_back(g0);
    if (er0) errs0++;
  endtask

  task automatic idle_n(input int n, input int dp);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 4'b0000, $urandom, dp);
  endtask

  logic [3:0] rot[5];

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    done0 = 1'b0; done1 = 1'b0;

    // reset state
    cyc(1'b1, 4'b0000, 32'h0, 99);
    cyc(1'b1, 4'b1111, 32'hFFFF_FFFF, 99);

    // single request, done at wait cycle 10
    cyc(1'b0, 4'b0100, 32'h00A5_0000, 10);
    chk("single_g",  32'(g0),   32'h4);
    chk("single_d",  32'(txd0), 32'hA5);
    idle_n(30, 10);
    chk("single_bz", 32'(bz0), 32'h0);

    // fairness with everyone requesting
    cyc(1'b1, 4'b0000, 32'h0, 99);
    collect = 1;
    for (int i = 0; i < 120; i++)
      cyc(1'b0, 4'b1111, $urandom, 5);
    collect = 0;
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("rr_len", 32'(gq.size() >= 5), 32'h1);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      chk("rr_ord", 32'(gq[i]), 32'(rot[i]));
    for (int i = 1; i < gq.size(); i++)
      chk("rr_rep", 32'(gq[i] == gq[i-1]), 32'h0);

    // timeout, then a normal transfer
    cyc(1'b1, 4'b0000, 32'h0, 99);
    errs0 = 0;
    cyc(1'b0, 4'b0001, 32'h0000_003C, 99);
    idle_n(40, 99);
    chk("to_cnt", 32'(errs0), 32'h1);
    cyc(1'b0, 4'b1000, 32'h7E00_0000, 3);
    idle_n(25, 3);

    // done collides with the last wait cycle
    errs0 = 0;
    cyc(1'b0, 4'b0010, 32'h0000_5A00, TO - 1);
    idle_n(40, TO - 1);
    chk("coll", 32'(errs0), 32'h0);

    // reset in the middle of a transfer
    cyc(1'b0, 4'b0010, 32'h0000_1100, 99);
    idle_n(3, 99);
    cyc(1'b1, 4'b0000, 32'h0, 99);
    chk("rst_bz", 32'(bz0), 32'h0);
    cyc(1'b0, 4'b0001, 32'h0000_0077, 99);
    chk("rst_rr", 32'(g0), 32'h1);
    idle_n(40, 2);

    // data changes after grant must not leak into tx_data
    cyc(1'b0, 4'b0100, 32'h0033_0000, 4);
    for (int i = 0; i < 30; i++)
      cyc(1'b0, 4'b0000, $urandom, 4);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      cyc(($urandom_range(0, 299) == 0), rq, $urandom, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
